// File: rtl/alarm_pkg.sv
// Shared alarm types: FSM states, SPI command bytes and the HEX digit encoder.
// Pure definitions; no latency, no flow control.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED,
        ST_EXIT,
        ST_ARMED,
        ST_ENTRY,
        ST_ALARM,
        ST_LOCKOUT
    } state_t;

    localparam logic [7:0] CMD_DISARMED = 8'hBA;
    localparam logic [7:0] CMD_ARMED    = 8'hBB;
    localparam logic [7:0] CMD_ENTRY    = 8'hBC;
    localparam logic [7:0] CMD_ALARM    = 8'hBD;
    localparam logic [7:0] CMD_EXIT     = 8'hBE;
    localparam logic [7:0] CMD_LOCKOUT  = 8'hBF;

    function automatic logic [7:0] state_cmd(input state_t s);
        case (s)
            ST_DISARMED: state_cmd = CMD_DISARMED;
            ST_EXIT:     state_cmd = CMD_EXIT;
            ST_ARMED:    state_cmd = CMD_ARMED;
            ST_ENTRY:    state_cmd = CMD_ENTRY;
            ST_ALARM:    state_cmd = CMD_ALARM;
            ST_LOCKOUT:  state_cmd = CMD_LOCKOUT;
            default:     state_cmd = CMD_DISARMED;
        endcase
    endfunction

    // Active-low segments {g,f,e,d,c,b,a} as wired on the board HEX displays.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/uid_matcher.sv
// Assembles MSB-first UID bytes, checks frame length and compares against the table.
// Match/fail pulses one cycle after the last byte; no backpressure, every byte is accepted.
module uid_matcher #(
    parameter int UID_BYTES = 4,
    parameter int NUM_UIDS  = 2,
    parameter logic [NUM_UIDS*UID_BYTES*8-1:0] AUTH_UIDS = {32'h332C1EB7, 32'h336BF410}
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uid_valid_i,
    input  logic [7:0] uid_byte_i,
    input  logic       uid_last_i,
    output logic       match_o,
    output logic       fail_o
);
    localparam int W = UID_BYTES * 8;

    logic [W-1:0] buf_q;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_inc;
    logic         pend_q;
    logic         len_ok_q;
    logic         hit;

    assign cnt_inc = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            len_ok_q <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (uid_valid_i) begin
                // Overlong frames keep counting but stop shifting, so they always fail on length.
                if (cnt_q < 4'(UID_BYTES))
                    buf_q <= (buf_q << 8) | W'(uid_byte_i);
                if (uid_last_i) begin
                    cnt_q    <= '0;
                    pend_q   <= 1'b1;
                    len_ok_q <= (cnt_inc == 4'(UID_BYTES));
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_UIDS; i++)
            if (AUTH_UIDS[i*W +: W] == buf_q)
                hit = 1'b1;
    end

    assign match_o = pend_q & len_ok_q & hit;
    assign fail_o  = pend_q & ~(len_ok_q & hit);

endmodule

// File: rtl/alarm_zone_controller.sv
// Alarm core: arm/disarm FSM, zone watch, exit/entry/lockout timers and UID auth.
// Outputs registered with the state; zone decision 2 cycles after input, UID result 1 cycle after last byte.
module alarm_zone_controller
    import alarm_pkg::*;
#(
    parameter int NUM_ZONES   = 4,
    parameter int UID_BYTES   = 4,
    parameter int NUM_UIDS    = 2,
    parameter logic [NUM_UIDS*UID_BYTES*8-1:0] AUTH_UIDS = {32'h332C1EB7, 32'h336BF410},
    parameter int TICK_DIV    = 50000000,
    parameter int EXIT_SEC    = 10,
    parameter int ENTRY_SEC   = 60,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_SEC = 30
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 arm_req,
    input  logic [NUM_ZONES-1:0] zone_in,
    input  logic [NUM_ZONES-1:0] zone_mask,
    input  logic                 uid_valid,
    input  logic [7:0]           uid_byte,
    input  logic                 uid_last,
    output logic [7:0]           state_code,
    output logic                 engaged,
    output logic                 buzzer,
    output logic                 authenticated,
    output logic                 auth_fail,
    output logic [7:0]           secs_left,
    output logic [NUM_ZONES-1:0] tripped_zones,
    output logic                 lockout
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);

    state_t               state_q, state_d;
    logic [7:0]           code_q, secs_q, secs_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [FW-1:0]        fails_q, fails_d;
    logic                 auth_q, auth_d, afail_q, afail_d;
    logic                 engaged_q, buzzer_q, lockout_q;
    logic [NUM_ZONES-1:0] z1_q, z2_q, trip_q, trip_d, zone_hit;
    logic                 uid_match, uid_fail, timed, expire;

    uid_matcher #(
        .UID_BYTES (UID_BYTES),
        .NUM_UIDS  (NUM_UIDS),
        .AUTH_UIDS (AUTH_UIDS)
    ) u_uid_matcher (
        .clk_i       (CLOCK_50),
        .reset_i     (reset),
        .uid_valid_i (uid_valid),
        .uid_byte_i  (uid_byte),
        .uid_last_i  (uid_last),
        .match_o     (uid_match),
        .fail_o      (uid_fail)
    );

    assign zone_hit = z2_q & zone_mask;
    assign timed    = state_q inside {ST_EXIT, ST_ENTRY, ST_LOCKOUT};

    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        tick_d  = tick_q;
        fails_d = fails_q;
        auth_d  = auth_q;
        afail_d = 1'b0;
        trip_d  = trip_q;
        expire  = 1'b0;

        // The tick that takes secs 1 -> 0 is also the expiry, so dwell is N*TICK_DIV.
        if (timed) begin
            if (secs_q == 8'd0) begin
                expire = 1'b1;
            end else if (tick_q == TICK_LAST) begin
                tick_d = '0;
                secs_d = secs_q - 8'd1;
                expire = (secs_q == 8'd1);
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        if (state_q inside {ST_ARMED, ST_ENTRY, ST_ALARM})
            trip_d = trip_q | zone_hit;

        if (uid_match && state_q != ST_LOCKOUT) begin
            auth_d = 1'b1;
            if (state_q != ST_DISARMED) begin
                state_d = ST_DISARMED;
                fails_d = '0;
                secs_d  = '0;
                tick_d  = '0;
            end
        end else if (uid_fail && state_q != ST_LOCKOUT) begin
            afail_d = 1'b1;
            if (state_q != ST_DISARMED) begin
                fails_d = fails_q + 1'b1;
                if (fails_q == FAIL_LAST) begin
                    state_d = ST_LOCKOUT;
                    secs_d  = 8'(LOCKOUT_SEC);
                    tick_d  = '0;
                end
            end
        end else if (expire) begin
            case (state_q)
                ST_EXIT:    state_d = ST_ARMED;
                ST_ENTRY:   state_d = ST_ALARM;
                ST_LOCKOUT: begin
                    state_d = ST_ALARM;
                    fails_d = '0;
                end
                default:    state_d = state_q;
            endcase
            secs_d = '0;
            tick_d = '0;
        end else if (state_q == ST_ARMED && |zone_hit) begin
            state_d = ST_ENTRY;
            secs_d  = 8'(ENTRY_SEC);
            tick_d  = '0;
        end else if (state_q == ST_DISARMED && arm_req) begin
            state_d = ST_EXIT;
            secs_d  = 8'(EXIT_SEC);
            tick_d  = '0;
            auth_d  = 1'b0;
            trip_d  = '0;
            fails_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_DISARMED;
            code_q    <= CMD_DISARMED;
            engaged_q <= 1'b0;
            buzzer_q  <= 1'b0;
            lockout_q <= 1'b0;
            secs_q    <= '0;
            tick_q    <= '0;
            fails_q   <= '0;
            auth_q    <= 1'b0;
            afail_q   <= 1'b0;
            trip_q    <= '0;
            z1_q      <= '0;
            z2_q      <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= state_cmd(state_d);
            engaged_q <= (state_d != ST_DISARMED);
            buzzer_q  <= (state_d == ST_ALARM) || (state_d == ST_LOCKOUT);
            lockout_q <= (state_d == ST_LOCKOUT);
            secs_q    <= secs_d;
            tick_q    <= tick_d;
            fails_q   <= fails_d;
            auth_q    <= auth_d;
            afail_q   <= afail_d;
            trip_q    <= trip_d;
            z1_q      <= zone_in;
            z2_q      <= z1_q;
        end
    end

    assign state_code    = code_q;
    assign engaged       = engaged_q;
    assign buzzer        = buzzer_q;
    assign lockout       = lockout_q;
    assign authenticated = auth_q;
    assign auth_fail     = afail_q;
    assign secs_left     = secs_q;
    assign tripped_zones = trip_q;

endmodule
